// File: rtl/scan_chain_seq.sv
// scan_chain_seq: shifts a pattern into a negedge-clocked scan chain, pulses one capture,
// then unloads the response. Define SCAN_CHAIN_SEQ_CMP_EN to add the expected-response compare.
module scan_chain_seq #(
  parameter int   CHAIN_LEN = 16,
  parameter logic FILL      = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] pat_in_i,
  input  logic                 so_i,
`ifdef SCAN_CHAIN_SEQ_CMP_EN
  input  logic [CHAIN_LEN-1:0] exp_in_i,
  output logic                 fail_o,
`endif
  output logic                 se_o,
  output logic                 si_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CHAIN_LEN-1:0] resp_o
);

  // state   | meaning
  // IDLE    | waiting for start_i, SE/SI low
  // SHIFT   | pattern shifted in MSB first, CHAIN_LEN cycles
  // CAPTURE | SE low for one cycle, chain loads its D inputs
  // UNLOAD  | remaining response shifted out, CHAIN_LEN-1 cycles

  localparam int CW = $clog2(CHAIN_LEN) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 fail_q, fail_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
      exp_q   <= '0;
      fail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
      exp_q   <= exp_d;
      fail_q  <= fail_d;
`endif
    end
  end

  // Outputs are registered, so each branch computes SE/SI for the cycle it enters.
  // pat_q is kept pre-shifted: its MSB is always the next bit to drive on SI.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    resp_d  = resp_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_d   = exp_q;
    fail_d  = fail_q;
`endif

    if (state_q == CAPTURE || state_q == UNLOAD) begin
      resp_d = {resp_q[CHAIN_LEN-2:0], so_i};
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          pat_d   = {pat_in_i[CHAIN_LEN-2:0], 1'b0};
          busy_d  = 1'b1;
          se_d    = 1'b1;
          si_d    = pat_in_i[CHAIN_LEN-1];
`ifdef SCAN_CHAIN_SEQ_CMP_EN
          exp_d   = exp_in_i;
          fail_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(CHAIN_LEN - 1)) begin
          state_d = CAPTURE;
          si_d    = FILL;
        end else begin
          cnt_d = cnt_q + CW'(1);
          pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
          se_d  = 1'b1;
          si_d  = pat_q[CHAIN_LEN-1];
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        cnt_d   = '0;
        busy_d  = 1'b1;
        se_d    = 1'b1;
        si_d    = FILL;
      end
      UNLOAD: begin
        if (cnt_q == CW'(CHAIN_LEN - 2)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
          fail_d  = (resp_d != exp_q);
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          se_d   = 1'b1;
          si_d   = FILL;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign se_o   = se_q;
  assign si_o   = si_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign resp_o = resp_q;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
  assign fail_o = fail_q;
`endif

endmodule

// File: tb/tb_scan_chain_seq.sv
// Bench for scan_chain_seq with a 4-flop negedge scan chain model whose capture behaviour
// (hold, invert, or load a fixed data word) defines the expected response.
module tb_scan_chain_seq;

  localparam int   CL     = 4;
  localparam logic FILL_V = 1'b0;
  localparam int   M_HOLD = 0;
  localparam int   M_INV  = 1;
  localparam int   M_DATA = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CL-1:0] pat_in = '0;
  logic          so;
  logic          se, si, busy, done;
  logic [CL-1:0] resp;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
  logic [CL-1:0] exp_in = '0;
  logic          fail;
`endif

  int n_vec = 0;
  int n_err = 0;

  int            mode = M_HOLD;
  logic [CL-1:0] dvec = '0;
  logic [CL-1:0] chain = '0;

  scan_chain_seq #(.CHAIN_LEN(CL), .FILL(FILL_V)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .pat_in_i (pat_in),
    .so_i     (so),
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    .exp_in_i (exp_in),
    .fail_o   (fail),
`endif
    .se_o     (se),
    .si_o     (si),
    .busy_o   (busy),
    .done_o   (done),
    .resp_o   (resp)
  );

  always #5 clk = ~clk;

  // Chain flop i sits at chain[i]; SI enters flop 0, SO leaves flop CL-1.
  always @(negedge clk) begin
    if (se) chain <= {chain[CL-2:0], si};
    else begin
      case (mode)
        M_HOLD:  chain <= chain;
        M_INV:   chain <= ~chain;
        default: chain <= dvec;
      endcase
    end
  end
  assign so = chain[CL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whatever the chain loads on its capture edge is what must come back in RESP.
  function automatic logic [CL-1:0] model_resp(input int m, input logic [CL-1:0] pat,
                                               input logic [CL-1:0] dv);
    case (m)
      M_HOLD:  return pat;
      M_INV:   return ~pat;
      default: return dv;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence from IDLE and checks the cycle-by-cycle SE/SI/BUSY timeline.
  task automatic run_seq(input logic [CL-1:0] pat, input logic [CL-1:0] exp_resp,
                         input bit hold_start);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    logic [CL-1:0] exp_lat;
    exp_lat = exp_in;
`endif
    chk("idle_busy", busy, 0);
    start  = 1'b1;
    pat_in = pat;
    tick();
    if (hold_start) pat_in = '0;
    else start = 1'b0;
    for (int k = 0; k < 2*CL; k++) begin
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("se", se, (k != CL));
      if (k < CL) chk("si_shift", si, pat[CL-1-k]);
      else        chk("si_fill", si, FILL_V);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
      if (k == 0) chk("fail_clr", fail, 0);
`endif
      tick();
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("se_end", se, 0);
    chk("resp", resp, exp_resp);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    chk("fail", fail, (exp_resp != exp_lat));
`endif
  endtask

  // Starts a sequence, then pulses reset during busy cycle cyc and checks the aftermath.
  task automatic reset_mid(input logic [CL-1:0] pat, input int cyc);
    int seen;
    start  = 1'b1;
    pat_in = pat;
    tick();
    start = 1'b0;
    repeat (cyc) @(posedge clk);
    #2;
    chk("busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_se", se, 0);
    chk("rst_si", si, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (2*CL + 2) begin
      tick();
      if (done) seen++;
    end
    chk("no_done_after_rst", seen, 0);
  endtask

  initial begin
    logic [CL-1:0] p;
    logic [CL-1:0] e;

    #2;
    chk("init_se", se, 0);
    chk("init_si", si, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_resp", resp, 0);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    chk("init_fail", fail, 0);
`endif
    tick();
    rst = 1'b0;
    repeat (2) tick();

    mode = M_HOLD;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_in = 4'b1011;
`endif
    run_seq(4'b1011, 4'b1011, 1'b0);
    tick();

    mode = M_INV;
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_in = 4'b0100;
`endif
    run_seq(4'b1011, 4'b0100, 1'b0);
    tick();

    mode = M_HOLD;
    reset_mid(4'b1001, 2);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_in = 4'b0110;
`endif
    run_seq(4'b0110, 4'b0110, 1'b0);
    tick();

    reset_mid(4'b1111, 6);

    // START held through the busy window with a zero pattern, then re-accepted on DONE.
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_in = 4'b1011;
`endif
    run_seq(4'b1011, 4'b1011, 1'b1);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
    exp_in = 4'b0000;
`endif
    run_seq(4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      mode = int'($urandom_range(0, 2));
      dvec = CL'($urandom);
      p    = CL'($urandom);
      e    = model_resp(mode, p, dvec);
`ifdef SCAN_CHAIN_SEQ_CMP_EN
      exp_in = ($urandom_range(0, 1) == 1) ? e : CL'($urandom);
`endif
      run_seq(p, e, 1'b0);
    end

`ifdef SCAN_CHAIN_SEQ_CMP_EN
    tick();
    mode   = M_HOLD;
    exp_in = 4'b1011;
    run_seq(4'b1011, 4'b1011, 1'b0);
    chk("cmp_match", fail, 0);
    tick();
    exp_in = 4'b1111;
    run_seq(4'b1011, 4'b1011, 1'b0);
    chk("cmp_mismatch", fail, 1);
    repeat (3) tick();
    chk("cmp_hold", fail, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
